// File: rtl/fetch_buffer.sv
`timescale 1ns/1ps
// fetch_buffer: circular queue of dual-instruction fetch packets between the
// IF/icache stage and the FIFO->ID register. The oldest packet is presented
// first-word-fall-through on the fifo_* bus.
// Optional feature: define FETCH_BUF_BYPASS_EN to let a packet pass
// combinationally from if_* to fifo_* when the buffer is empty.
module fetch_buffer #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] INST_NOP = 32'h0340_0000,
  parameter logic [31:0] PC_RESET = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_buf_flush,
  input  logic        if_valid,
  output logic        fetch_buf_ready,
  input  logic [31:0] if_inst0,
  input  logic [31:0] if_inst1,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_pcAdd,
  input  logic [31:0] if_pc_next,
  input  logic [31:0] if_badv,
  input  logic [31:0] if_cookie_out,
  input  logic [6:0]  if_exception,
  input  logic [1:0]  if_excp_flag,
  input  logic [1:0]  if_ibar_flag,
  input  logic        if_cacop_ready,
  input  logic        if_cacop_complete,
  output logic        fifo_valid,
  input  logic        fifo_ready,
  output logic [31:0] fifo_inst0,
  output logic [31:0] fifo_inst1,
  output logic [31:0] fifo_pc,
  output logic [31:0] fifo_pcAdd,
  output logic [31:0] fifo_pc_next,
  output logic [31:0] fifo_badv,
  output logic [31:0] fifo_cookie_out,
  output logic [6:0]  fifo_exception,
  output logic [1:0]  fifo_excp_flag,
  output logic [1:0]  fifo_ibar_flag,
  output logic        fifo_cacop_ready,
  output logic        fifo_cacop_complete,
  output logic        fetch_buf_empty,
  output logic        fetch_buf_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = 7 * 32 + 7 + 2 + 2 + 1 + 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [PW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_rp;
  logic [AW:0]   r_wp;

  logic [PW-1:0] w_in;
  logic [PW-1:0] w_empty_pkt;
  logic [PW-1:0] w_out;
  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  assign w_in = {if_inst0, if_inst1, if_pc, if_pcAdd, if_pc_next, if_badv,
                 if_cookie_out, if_exception, if_excp_flag, if_ibar_flag,
                 if_cacop_ready, if_cacop_complete};

  assign w_empty_pkt = {INST_NOP, INST_NOP, PC_RESET, PC_RESET, PC_RESET,
                        PC_RESET, PC_RESET, 7'd0, 2'd0, 2'd0, 1'b0, 1'b0};

  // Wrap bit (MSB) separates full from empty when the index bits match.
  assign w_empty = (r_rp == r_wp);
  assign w_full  = (r_rp[AW-1:0] == r_wp[AW-1:0]) && (r_rp[AW] != r_wp[AW]);

`ifdef FETCH_BUF_BYPASS_EN
  assign w_bypass = w_empty && if_valid && !fetch_buf_flush;
`else
  assign w_bypass = 1'b0;
`endif

  // Ready depends only on registered state, so a pop never opens a push slot
  // in the same cycle.
  assign fetch_buf_ready = !w_full;
  assign w_pop  = !w_empty && fifo_ready && !fetch_buf_flush;
  assign w_push = if_valid && !w_full && !fetch_buf_flush &&
                  !(w_bypass && fifo_ready);

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rp <= '0;
      r_wp <= '0;
    end else if (fetch_buf_flush) begin
      r_rp <= '0;
      r_wp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_ONE;
      if (w_pop)  r_rp <= r_rp + PTR_ONE;
    end
  end

  // Packet storage is deliberately left unreset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= w_in;
  end

  // Head packet selection: bypass input, stored head, or the idle packet.
  always_comb begin
    w_out = w_empty_pkt;
    if (w_bypass)      w_out = w_in;
    else if (!w_empty) w_out = r_mem[r_rp[AW-1:0]];
  end

  assign {fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next, fifo_badv,
          fifo_cookie_out, fifo_exception, fifo_excp_flag, fifo_ibar_flag,
          fifo_cacop_ready, fifo_cacop_complete} = w_out;

  assign fifo_valid      = w_bypass || !w_empty;
  assign fetch_buf_empty = w_empty;
  assign fetch_buf_full  = w_full;

endmodule

// File: tb/tb_fetch_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for fetch_buffer: accepted packets are queued by PC and
// compared field-by-field when the head is consumed.
module tb_fetch_buffer;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h0340_0000;
  localparam logic [31:0] PCR   = 32'h1C00_0000;

  logic        clk;
  logic        rstn;
  logic        fetch_buf_flush;
  logic        if_valid;
  logic        fetch_buf_ready;
  logic [31:0] if_inst0, if_inst1, if_pc, if_pcAdd, if_pc_next, if_badv, if_cookie_out;
  logic [6:0]  if_exception;
  logic [1:0]  if_excp_flag, if_ibar_flag;
  logic        if_cacop_ready, if_cacop_complete;
  logic        fifo_valid;
  logic        fifo_ready;
  logic [31:0] fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next, fifo_badv, fifo_cookie_out;
  logic [6:0]  fifo_exception;
  logic [1:0]  fifo_excp_flag, fifo_ibar_flag;
  logic        fifo_cacop_ready, fifo_cacop_complete;
  logic        fetch_buf_empty;
  logic        fetch_buf_full;
  logic [236:0] fifo_bus;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] q[$];
  logic [31:0] cur_pc;

  fetch_buffer #(.DEPTH(DEPTH), .INST_NOP(NOP), .PC_RESET(PCR)) dut (
    .clk(clk), .rstn(rstn), .fetch_buf_flush(fetch_buf_flush),
    .if_valid(if_valid), .fetch_buf_ready(fetch_buf_ready),
    .if_inst0(if_inst0), .if_inst1(if_inst1), .if_pc(if_pc), .if_pcAdd(if_pcAdd),
    .if_pc_next(if_pc_next), .if_badv(if_badv), .if_cookie_out(if_cookie_out),
    .if_exception(if_exception), .if_excp_flag(if_excp_flag), .if_ibar_flag(if_ibar_flag),
    .if_cacop_ready(if_cacop_ready), .if_cacop_complete(if_cacop_complete),
    .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1), .fifo_pc(fifo_pc),
    .fifo_pcAdd(fifo_pcAdd), .fifo_pc_next(fifo_pc_next), .fifo_badv(fifo_badv),
    .fifo_cookie_out(fifo_cookie_out), .fifo_exception(fifo_exception),
    .fifo_excp_flag(fifo_excp_flag), .fifo_ibar_flag(fifo_ibar_flag),
    .fifo_cacop_ready(fifo_cacop_ready), .fifo_cacop_complete(fifo_cacop_complete),
    .fetch_buf_empty(fetch_buf_empty), .fetch_buf_full(fetch_buf_full)
  );

  assign fifo_bus = {fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next, fifo_badv,
                     fifo_cookie_out, fifo_exception, fifo_excp_flag, fifo_ibar_flag,
                     fifo_cacop_ready, fifo_cacop_complete};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [236:0] pkt(input logic [31:0] pc);
    pkt = {pc ^ 32'hA5A5_0000, ~pc, pc, pc + 32'd4, pc + 32'd8, pc ^ 32'h0F0F_0F0F,
           pc + 32'h100, pc[8:2], pc[4:3], pc[6:5], pc[3], pc[4]};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    if_valid = v;
    cur_pc   = pc;
    {if_inst0, if_inst1, if_pc, if_pcAdd, if_pc_next, if_badv, if_cookie_out,
     if_exception, if_excp_flag, if_ibar_flag, if_cacop_ready, if_cacop_complete} = pkt(pc);
  endtask

  // One clock of scoreboard bookkeeping: status flags against the model
  // count, then push on acceptance and compare the head on consumption.
  task automatic sb_cycle(input string name);
    int          n;
    logic        exp_valid;
    logic [3:0]  exp_flags;
    logic [31:0] hp;
    #1;
    n = q.size();
    exp_valid = (n != 0);
`ifdef FETCH_BUF_BYPASS_EN
    if (n == 0 && if_valid && !fetch_buf_flush) exp_valid = 1'b1;
`endif
    exp_flags = {exp_valid, n == 0, n == DEPTH, n != DEPTH};
    tests_run++;
    if ({fifo_valid, fetch_buf_empty, fetch_buf_full, fetch_buf_ready} !== exp_flags) begin
      tests_failed++;
      $display("FAIL %s flags{valid,empty,full,ready}: got %b want %b", name,
               {fifo_valid, fetch_buf_empty, fetch_buf_full, fetch_buf_ready}, exp_flags);
    end
    if (fetch_buf_flush) q.delete();
    else begin
      if (if_valid && n != DEPTH) q.push_back(cur_pc);
      if (exp_valid && fifo_ready && q.size() > 0) begin
        hp = q.pop_front();
        tests_run++;
        if (fifo_bus !== pkt(hp)) begin
          tests_failed++;
          $display("FAIL %s head packet: got pc %h inst0 %h want pc %h inst0 %h", name,
                   fifo_pc, fifo_inst0, hp, hp ^ 32'hA5A5_0000);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({fifo_valid, fetch_buf_empty, fetch_buf_full, fetch_buf_ready} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 0101",
               {fifo_valid, fetch_buf_empty, fetch_buf_full, fetch_buf_ready});
    end
    tests_run++;
    if (fifo_bus !== {NOP, NOP, PCR, PCR, PCR, PCR, PCR, 13'd0}) begin
      tests_failed++;
      $display("FAIL reset_fields: got inst0 %h pc %h exc %h want inst0 %h pc %h exc 0",
               fifo_inst0, fifo_pc, fifo_exception, NOP, PCR);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    fifo_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1C00_0000 + 32'(8 * i));
      sb_cycle("basic_push");
    end
    drive(1'b0, 32'h0);
    #1;
    tests_run++;
    if (fifo_valid !== 1'b1 || fifo_pc !== 32'h1C00_0000 || fetch_buf_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_head: got valid %b pc %h empty %b want 1 1c000000 0",
               fifo_valid, fifo_pc, fetch_buf_empty);
    end
    fifo_ready = 1'b1;
    for (int i = 0; i < 3; i++) sb_cycle("basic_pop");
    fifo_ready = 1'b0;
    #1;
    tests_run++;
    if (fetch_buf_empty !== 1'b1 || fifo_inst0 !== NOP || fifo_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_drained: got empty %b inst0 %h valid %b want 1 %h 0",
               fetch_buf_empty, fifo_inst0, fifo_valid, NOP);
    end
  endtask

  task automatic test_full();
    @(negedge clk);
    fifo_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h1C00_1000 + 32'(8 * i));
      sb_cycle("full_fill");
    end
    drive(1'b1, 32'h1C00_1040);
    fifo_ready = 1'b1;
    #1;
    tests_run++;
    if (fetch_buf_full !== 1'b1 || fetch_buf_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_status: got full %b ready %b want 1 0", fetch_buf_full, fetch_buf_ready);
    end
    sb_cycle("full_ninth_pop");
    fifo_ready = 1'b0;
    #1;
    tests_run++;
    if (fetch_buf_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_ready_after_pop: got %b want 1", fetch_buf_ready);
    end
    sb_cycle("full_ninth_accept");
    drive(1'b0, 32'h0);
    #1;
    tests_run++;
    if (fetch_buf_full !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_refilled: got %b want 1", fetch_buf_full);
    end
    fifo_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) sb_cycle("full_drain");
    fifo_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    fifo_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h1C00_2000 + 32'(8 * i));
      sb_cycle("wrap");
      tests_run++;
`ifdef FETCH_BUF_BYPASS_EN
      if (fetch_buf_empty !== 1'b1 || fetch_buf_full !== 1'b0) begin
`else
      if (fetch_buf_empty !== 1'b0 || fetch_buf_full !== 1'b0) begin
`endif
        tests_failed++;
        $display("FAIL wrap_count: got empty %b full %b at packet %0d",
                 fetch_buf_empty, fetch_buf_full, i);
      end
    end
    drive(1'b0, 32'h0);
    sb_cycle("wrap_drain");
    fifo_ready = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk);
    fifo_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1C00_3000 + 32'(8 * i));
      sb_cycle("flush_fill");
    end
    drive(1'b1, 32'h1C00_30F0);
    fetch_buf_flush = 1'b1;
    sb_cycle("flush_cycle");
    fetch_buf_flush = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    tests_run++;
    if (fetch_buf_empty !== 1'b1 || fifo_valid !== 1'b0 || fetch_buf_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_empty: got empty %b valid %b ready %b want 1 0 1",
               fetch_buf_empty, fifo_valid, fetch_buf_ready);
    end
    drive(1'b1, 32'h1C00_3100);
    sb_cycle("flush_refill");
    drive(1'b0, 32'h0);
    fifo_ready = 1'b1;
    sb_cycle("flush_after_pop");
    fifo_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    fifo_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1C00_4000 + 32'(8 * i));
      sb_cycle("arst_fill");
    end
    drive(1'b0, 32'h0);
    #2 rstn = 1'b0;
    #1;
    tests_run++;
    if (fifo_valid !== 1'b0 || fetch_buf_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL arst_immediate: got valid %b empty %b want 0 1", fifo_valid, fetch_buf_empty);
    end
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    tests_run++;
    if (fetch_buf_empty !== 1'b1 || fifo_inst0 !== NOP) begin
      tests_failed++;
      $display("FAIL arst_release: got empty %b inst0 %h want 1 %h", fetch_buf_empty, fifo_inst0, NOP);
    end
    @(negedge clk);
    drive(1'b1, 32'h1C00_4100);
    sb_cycle("arst_push");
    drive(1'b0, 32'h0);
    fifo_ready = 1'b1;
    sb_cycle("arst_pop");
    fifo_ready = 1'b0;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive(1'b1, 32'h1C00_5000);
    if_inst0   = 32'h0280_0421;
    fifo_ready = 1'b1;
    #1;
    tests_run++;
`ifdef FETCH_BUF_BYPASS_EN
    if (fifo_valid !== 1'b1 || fifo_inst0 !== 32'h0280_0421) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: got valid %b inst0 %h want 1 02800421", fifo_valid, fifo_inst0);
    end
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 32'h0);
    fifo_ready = 1'b0;
    #1;
    tests_run++;
    if (fetch_buf_empty !== 1'b1 || fifo_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_not_stored: got empty %b valid %b want 1 0", fetch_buf_empty, fifo_valid);
    end
`else
    if (fifo_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL nobypass_same_cycle: got valid %b want 0", fifo_valid);
    end
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 32'h0);
    fifo_ready = 1'b0;
    #1;
    tests_run++;
    if (fifo_valid !== 1'b1 || fifo_inst0 !== 32'h0280_0421) begin
      tests_failed++;
      $display("FAIL nobypass_next_cycle: got valid %b inst0 %h want 1 02800421", fifo_valid, fifo_inst0);
    end
    fifo_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fifo_ready = 1'b0;
    #1;
    tests_run++;
    if (fetch_buf_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL nobypass_drained: got empty %b want 1", fetch_buf_empty);
    end
`endif
  endtask

  initial begin
    rstn            = 1'b0;
    fetch_buf_flush = 1'b0;
    fifo_ready      = 1'b0;
    drive(1'b0, 32'h0);
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
    $fatal(1, "time limit");
  end

endmodule
